// File: rtl/comparator_seq.sv
`default_nettype none
// ============================================================================
// Module   : comparator_seq
// Brief    : MSB-first chunk-serial magnitude comparator with early exit,
//            signed/unsigned modes and a start/busy/done handshake.
// Revision : 1.0 - initial release
// ============================================================================
module comparator_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic             signed_mode,
    output logic             busy,
    output logic             done,
    output logic             less,
    output logic             great,
    output logic             eq
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = $clog2(N) + 1;

    localparam logic [CW-1:0]    C_LAST      = CW'(N - 1);
    localparam logic [DIGIT-1:0] C_SIGN_MASK = DIGIT'(1) << (DIGIT - 1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sgn_q, sgn_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic             less_q, less_d;
    logic             great_q, great_d;
    logic             eq_q, eq_d;
    logic             done_q, done_d;

    logic [WIDTH-1:0] w_a_shl;
    logic [WIDTH-1:0] w_b_shl;
    logic [DIGIT-1:0] w_chunk_a;
    logic [DIGIT-1:0] w_chunk_b;
    logic             w_top;

    // Operands shift left so the chunk under test always sits at the MSB end.
    generate
        if (N > 1) begin : g_shift
            assign w_a_shl = {a_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
            assign w_b_shl = {b_q[WIDTH-DIGIT-1:0], {DIGIT{1'b0}}};
        end else begin : g_noshift
            assign w_a_shl = a_q;
            assign w_b_shl = b_q;
        end
    endgenerate

    // Flipping the sign bit of the top chunk maps two's-complement order onto unsigned order.
    assign w_top     = sgn_q && (idx_q == C_LAST);
    assign w_chunk_a = a_q[WIDTH-1 -: DIGIT] ^ (w_top ? C_SIGN_MASK : '0);
    assign w_chunk_b = b_q[WIDTH-1 -: DIGIT] ^ (w_top ? C_SIGN_MASK : '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
            idx_q   <= '0;
            less_q  <= 1'b0;
            great_q <= 1'b0;
            eq_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
            idx_q   <= idx_d;
            less_q  <= less_d;
            great_q <= great_d;
            eq_q    <= eq_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        idx_d   = idx_q;
        less_d  = less_q;
        great_d = great_q;
        eq_d    = eq_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = in1;
                    b_d     = in2;
                    sgn_d   = signed_mode;
                    idx_d   = C_LAST;
                    less_d  = 1'b0;
                    great_d = 1'b0;
                    eq_d    = 1'b0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (w_chunk_a != w_chunk_b) begin
                    great_d = (w_chunk_a > w_chunk_b);
                    less_d  = (w_chunk_a < w_chunk_b);
                    eq_d    = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else if (idx_q == '0) begin
                    great_d = 1'b0;
                    less_d  = 1'b0;
                    eq_d    = 1'b1;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    idx_d = idx_q - CW'(1);
                    a_d   = w_a_shl;
                    b_d   = w_b_shl;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign busy  = (state_q == S_RUN);
    assign done  = done_q;
    assign less  = less_q;
    assign great = great_q;
    assign eq    = eq_q;

endmodule
`default_nettype wire

// File: tb/tb_comparator_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_comparator_seq
// Brief    : Self-checking bench: behavioural reference plus directed cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_comparator_seq;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int N     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] in1 = '0;
    logic [WIDTH-1:0] in2 = '0;
    logic             signed_mode = 1'b0;
    logic             busy, done, less, great, eq;

    int n_checks = 0;
    int n_fail   = 0;

    comparator_seq #(.WIDTH(WIDTH), .DIGIT(DIGIT)) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in1         (in1),
        .in2         (in2),
        .signed_mode (signed_mode),
        .busy        (busy),
        .done        (done),
        .less        (less),
        .great       (great),
        .eq          (eq)
    );

    always #5 clk = ~clk;

    // Whole-value comparison; latency is one plus the count of equal leading chunks.
    function automatic void ref_cmp(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                    input logic s, output logic l, output logic g,
                                    output logic e, output int k);
        int same;
        if (s) begin
            l = ($signed(a) < $signed(b));
            g = ($signed(a) > $signed(b));
        end else begin
            l = (a < b);
            g = (a > b);
        end
        e = (a == b);
        same = 0;
        for (int i = N - 1; i >= 0; i--) begin
            if (((a >> (i * DIGIT)) & 16'hF) == ((b >> (i * DIGIT)) & 16'hF)) same++;
            else break;
        end
        k = (same >= N) ? N : same + 1;
    endfunction

    logic m_busy, m_done, m_l, m_g, m_e;
    logic p_l, p_g, p_e;
    int   m_rem;
    logic t_l, t_g, t_e;
    int   t_k;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0;
            m_l <= 1'b0; m_g <= 1'b0; m_e <= 1'b0;
            m_rem <= 0;
        end else begin
            m_done <= 1'b0;
            if (!m_busy) begin
                if (start) begin
                    ref_cmp(in1, in2, signed_mode, t_l, t_g, t_e, t_k);
                    p_l <= t_l; p_g <= t_g; p_e <= t_e;
                    m_rem  <= t_k;
                    m_busy <= 1'b1;
                    m_l <= 1'b0; m_g <= 1'b0; m_e <= 1'b0;
                end
            end else if (m_rem == 1) begin
                m_busy <= 1'b0;
                m_done <= 1'b1;
                m_l <= p_l; m_g <= p_g; m_e <= p_e;
            end else begin
                m_rem <= m_rem - 1;
            end
        end
    end

    always @(negedge clk) begin
        n_checks++;
        if ({busy, done, less, great, eq} !== {m_busy, m_done, m_l, m_g, m_e}) begin
            n_fail++;
            $display("FAIL cycle_compare t=%0t busy/done/less/great/eq got %b%b%b%b%b want %b%b%b%b%b",
                     $time, busy, done, less, great, eq, m_busy, m_done, m_l, m_g, m_e);
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic pin_model(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                             input logic s, input logic [2:0] lge, input int ek);
        logic l, g, e;
        int   k;
        ref_cmp(a, b, s, l, g, e, k);
        chk({nm, "_model_flags"}, int'({l, g, e}), int'(lge));
        chk({nm, "_model_k"}, k, ek);
    endtask

    // One compare from idle; optionally holds start and scrambles inputs while busy.
    task automatic do_cmp(input string nm, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic s, input logic hold, input logic [2:0] lge, input int ek);
        int   cyc;
        logic got;
        @(posedge clk); #1;
        in1 = a; in2 = b; signed_mode = s; start = 1'b1;
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 20) begin
            if (hold) begin
                in1 = WIDTH'($urandom); in2 = WIDTH'($urandom); signed_mode = 1'($urandom);
            end
            @(posedge clk); #1;
            cyc++;
            if (done) got = 1'b1;
        end
        start = 1'b0;
        chk({nm, "_done_seen"}, int'(got), 1);
        chk({nm, "_latency"}, cyc, ek);
        chk({nm, "_flags"}, int'({less, great, eq}), int'(lge));
        chk({nm, "_busy_in_done"}, int'(busy), 0);
    endtask

    initial begin
        int cyc;
        logic got;

        pin_model("pin_unsigned", 16'hA000, 16'h9FFF, 1'b0, 3'b010, 1);
        pin_model("pin_equal",    16'h1234, 16'h1234, 1'b0, 3'b001, 4);
        pin_model("pin_sign_s",   16'h8000, 16'h0001, 1'b1, 3'b100, 1);
        pin_model("pin_sign_u",   16'h8000, 16'h0001, 1'b0, 3'b010, 1);
        pin_model("pin_lsb",      16'h1235, 16'h1234, 1'b0, 3'b010, 4);
        pin_model("pin_neg1",     16'h0000, 16'hFFFF, 1'b1, 3'b010, 1);

        #1;
        chk("reset_outputs", int'({busy, done, less, great, eq}), 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        do_cmp("unsigned", 16'hA000, 16'h9FFF, 1'b0, 1'b0, 3'b010, 1);
        do_cmp("equal_hold", 16'h1234, 16'h1234, 1'b0, 1'b1, 3'b001, 4);
        do_cmp("sign_s", 16'h8000, 16'h0001, 1'b1, 1'b0, 3'b100, 1);
        do_cmp("sign_u", 16'h8000, 16'h0001, 1'b0, 1'b0, 3'b010, 1);
        do_cmp("lsb", 16'h1235, 16'h1234, 1'b0, 1'b0, 3'b010, 4);
        do_cmp("neg1", 16'h0000, 16'hFFFF, 1'b1, 1'b0, 3'b010, 1);

        // Abort mid-compare with asynchronous reset.
        @(posedge clk); #1;
        in1 = 16'h1234; in2 = 16'h1234; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_reset_busy", int'(busy), 1);
        rst_n = 1'b0;
        #1;
        chk("reset_abort_outputs", int'({busy, done, less, great, eq}), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_held_outputs", int'({busy, done, less, great, eq}), 0);
        rst_n = 1'b1;
        do_cmp("after_reset", 16'h4000, 16'h4001, 1'b0, 1'b0, 3'b100, 4);

        // Back-to-back: start issued in the done cycle.
        @(posedge clk); #1;
        in1 = 16'h7000; in2 = 16'h6000; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 1'b0; cyc = 0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (done) got = 1'b1;
        end
        chk("b2b_first_done", int'(got), 1);
        chk("b2b_first_flags", int'({less, great, eq}), 3'b010);
        in1 = 16'h0001; in2 = 16'h0002; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        chk("b2b_cleared", int'({busy, done, less, great, eq}), 5'b10000);
        got = 1'b0; cyc = 0;
        while (!got && cyc < 20) begin
            @(posedge clk); #1; cyc++;
            if (done) got = 1'b1;
        end
        chk("b2b_second_done", int'(got), 1);
        chk("b2b_latency", cyc, 4);
        chk("b2b_flags", int'({less, great, eq}), 3'b100);

        // Randomized traffic with biased equal leading chunks; checked every cycle.
        for (int i = 0; i < 3000; i++) begin
            logic [WIDTH-1:0] a, b;
            int keep;
            @(posedge clk); #1;
            a = WIDTH'($urandom);
            keep = $urandom_range(0, N);
            b = WIDTH'($urandom);
            for (int c = N - 1; c >= N - keep; c--) b[c*DIGIT +: DIGIT] = a[c*DIGIT +: DIGIT];
            in1 = a; in2 = b;
            signed_mode = 1'($urandom);
            start = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 400) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
        end
        @(posedge clk); #1 start = 1'b0;
        repeat (N + 2) @(posedge clk);
        @(negedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
